pong_frame_regs: RTL and testbench

- CPU-facing register bank that produces the object coordinates consumed by vga_control (paddle_x drives its mem_in).
- CPU writes go into shadow registers. Shadows are committed to the active outputs only at the start of vertical sync, so the picture never tears mid-frame.
- Also keeps a frame counter and clamps the paddle to the visible area.
- Sits between the CPU data-memory bus and vga_control; it replaces the bare vgaRegister holding stage.

---
 rtl/pong_vga_pkg.sv | 22 ++
 rtl/sync_edge_det.sv | 31 +++
 rtl/pong_frame_regs.sv | 188 ++++++++++++++++++
 tb/tb_pong_frame_regs.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_vga_pkg.sv
// Shared constants for the pong VGA datapath: register map, frame FSM
// encoding and visible-area geometry (also used by vga_control).
package pong_vga_pkg;

  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned PADDLE_W  = 160;

  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_PADDLE_X = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_BALL_X   = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_BALL_Y   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 3'd4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMMIT    = 2'd1,
    WAIT_HIGH = 2'd2
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous level plus a one-cycle pulse
// on each falling edge of the synchronized level.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Flops reset high so an idle (inactive-high) input never looks like an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign fall_o = prev_q & ~sync_q;

endmodule

// File: rtl/pong_frame_regs.sv
// CPU register bank with shadow registers committed to the active object
// coordinates at the start of vsync. Optional IRQ: PONG_FRAME_IRQ_EN.
module pong_frame_regs
  import pong_vga_pkg::ADDR_W, pong_vga_pkg::ADDR_PADDLE_X, pong_vga_pkg::ADDR_BALL_X,
         pong_vga_pkg::ADDR_BALL_Y, pong_vga_pkg::ADDR_STATUS, pong_vga_pkg::ADDR_CTRL,
         pong_vga_pkg::state_e, pong_vga_pkg::IDLE, pong_vga_pkg::COMMIT,
         pong_vga_pkg::WAIT_HIGH;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned H_VISIBLE = pong_vga_pkg::H_VISIBLE,
  parameter int unsigned PADDLE_W  = pong_vga_pkg::PADDLE_W,
  parameter int unsigned FCNT_W    = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              vsync_in,
  output logic [DATA_W-1:0] paddle_x,
  output logic [DATA_W-1:0] ball_x,
  output logic [DATA_W-1:0] ball_y,
  output logic              frame_tick,
  output logic [FCNT_W-1:0] frame_cnt
`ifdef PONG_FRAME_IRQ_EN
  ,
  output logic              frame_irq
`endif
);

  localparam logic [DATA_W-1:0] PADDLE_MAX = DATA_W'(H_VISIBLE - PADDLE_W);

  logic vs_sync;
  logic vs_fall;

  sync_edge_det u_vs_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (vsync_in),
    .sync_o  (vs_sync),
    .fall_o  (vs_fall)
  );

  state_e            state_q;
  logic [DATA_W-1:0] pad_sh_q, pad_sh_d;
  logic [DATA_W-1:0] bx_sh_q, bx_sh_d;
  logic [DATA_W-1:0] by_sh_q, by_sh_d;
  logic [DATA_W-1:0] pad_q, bx_q, by_q;
  logic              dirty_q, dirty_d;
  logic              freeze_q, freeze_d;
  logic              tick_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              commit_c;
  logic              wr_obj_c;
  logic              irq_bit_c;

  // CPU write path; a write landing in the commit cycle survives as dirty
  always_comb begin
    pad_sh_d = pad_sh_q;
    bx_sh_d  = bx_sh_q;
    by_sh_d  = by_sh_q;
    freeze_d = freeze_q;
    wr_obj_c = 1'b0;
    commit_c = (state_q == COMMIT) && !freeze_q && dirty_q;
    if (cpu_we) begin
      case (cpu_addr)
        ADDR_PADDLE_X: begin
          pad_sh_d = (cpu_wdata > PADDLE_MAX) ? PADDLE_MAX : cpu_wdata;
          wr_obj_c = 1'b1;
        end
        ADDR_BALL_X: begin
          bx_sh_d  = cpu_wdata;
          wr_obj_c = 1'b1;
        end
        ADDR_BALL_Y: begin
          by_sh_d  = cpu_wdata;
          wr_obj_c = 1'b1;
        end
        ADDR_CTRL: freeze_d = cpu_wdata[0];
        default: ;
      endcase
    end
    dirty_d = (dirty_q && !commit_c) || wr_obj_c;
  end

`ifdef PONG_FRAME_IRQ_EN
  logic irq_q, irq_d;

  // Set in the commit cycle wins over a coincident clear
  always_comb begin
    irq_d = irq_q;
    if (cpu_we && (cpu_addr == ADDR_STATUS)) irq_d = 1'b0;
    if (state_q == COMMIT)                   irq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq_bit_c = irq_q;
  assign frame_irq = irq_q;
`else
  assign irq_bit_c = 1'b0;
`endif

  // Read mux sees pre-write register values; data holds when not reading
  always_comb begin
    rdata_d = rdata_q;
    if (cpu_re) begin
      rdata_d = '0;
      case (cpu_addr)
        ADDR_PADDLE_X: rdata_d = pad_sh_q;
        ADDR_BALL_X:   rdata_d = bx_sh_q;
        ADDR_BALL_Y:   rdata_d = by_sh_q;
        ADDR_STATUS: begin
          rdata_d[0]          = dirty_q;
          rdata_d[1]          = irq_bit_c;
          rdata_d[FCNT_W+3:4] = fcnt_q;
        end
        ADDR_CTRL:     rdata_d[0] = freeze_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pad_sh_q <= '0;
      bx_sh_q  <= '0;
      by_sh_q  <= '0;
      dirty_q  <= 1'b0;
      freeze_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      pad_sh_q <= pad_sh_d;
      bx_sh_q  <= bx_sh_d;
      by_sh_q  <= by_sh_d;
      dirty_q  <= dirty_d;
      freeze_q <= freeze_d;
      rdata_q  <= rdata_d;
    end
  end

  // Frame FSM: one commit per vsync, re-armed only once vsync returns high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pad_q   <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      tick_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      tick_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (vs_fall) state_q <= COMMIT;
        end
        COMMIT: begin
          if (commit_c) begin
            pad_q <= pad_sh_q;
            bx_q  <= bx_sh_q;
            by_q  <= by_sh_q;
          end
          tick_q  <= 1'b1;
          fcnt_q  <= fcnt_q + FCNT_W'(1);
          state_q <= WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (vs_sync) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_rdata  = rdata_q;
  assign paddle_x   = pad_q;
  assign ball_x     = bx_q;
  assign ball_y     = by_q;
  assign frame_tick = tick_q;
  assign frame_cnt  = fcnt_q;

endmodule

// File: tb/tb_pong_frame_regs.sv
// Randomized bench for pong_frame_regs against a frame-level reference model.
module tb_pong_frame_regs;

  localparam int unsigned PMAX  = 480;
  localparam int unsigned FMOD  = 4096;

  logic        clk;
  logic        rst_n;
  logic [2:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [15:0] cpu_rdata;
  logic        vsync_in;
  logic [15:0] paddle_x;
  logic [15:0] ball_x;
  logic [15:0] ball_y;
  logic        frame_tick;
  logic [11:0] frame_cnt;
`ifdef PONG_FRAME_IRQ_EN
  logic        frame_irq;
`endif

  pong_frame_regs #(
    .DATA_W    (16),
    .H_VISIBLE (640),
    .PADDLE_W  (160),
    .FCNT_W    (12)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_we     (cpu_we),
    .cpu_re     (cpu_re),
    .cpu_rdata  (cpu_rdata),
    .vsync_in   (vsync_in),
    .paddle_x   (paddle_x),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .frame_tick (frame_tick),
    .frame_cnt  (frame_cnt)
`ifdef PONG_FRAME_IRQ_EN
    ,
    .frame_irq  (frame_irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [15:0] m_sh [3];
  logic [15:0] m_act [3];
  logic        m_dirty, m_freeze, m_irq, m_tick;
  int          m_fcnt;
  logic [15:0] m_rdata;
  int          commit_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] clampv(input logic [15:0] v);
    return (v > 16'(PMAX)) ? 16'(PMAX) : v;
  endfunction

  function automatic logic [15:0] model_read(input logic [2:0] a);
    logic [15:0] r;
    logic        irq_bit;
`ifdef PONG_FRAME_IRQ_EN
    irq_bit = m_irq;
`else
    irq_bit = 1'b0;
`endif
    case (a)
      3'd0, 3'd1, 3'd2: r = m_sh[a];
      3'd3: r = 16'((m_fcnt % FMOD) * 16) | {14'd0, irq_bit, m_dirty};
      3'd4: r = {15'd0, m_freeze};
      default: r = 16'd0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_sh[i]  = 16'd0;
      m_act[i] = 16'd0;
    end
    m_dirty = 1'b0; m_freeze = 1'b0; m_irq = 1'b0; m_tick = 1'b0;
    m_fcnt = 0; m_rdata = 16'd0; commit_in = -1;
  endtask

  // One clock cycle of CPU/vsync stimulus; called just after an active edge
  task automatic tick(input logic [2:0] a, input logic we, input logic re,
                      input logic [15:0] wd, input logic vs);
    logic commit_now;
    cpu_addr = a; cpu_we = we; cpu_re = re; cpu_wdata = wd;
    // The pin's falling edge is committed on the fourth clock edge after it
    if (!vs && vsync_in) commit_in = 4;
    vsync_in = vs;
    @(posedge clk);
    if (re) m_rdata = model_read(a);
    commit_now = 1'b0;
    if (commit_in > 0) begin
      commit_in--;
      if (commit_in == 0) begin
        commit_now = 1'b1;
        commit_in  = -1;
      end
    end
    m_tick = commit_now;
    if (commit_now) begin
      if (!m_freeze && m_dirty) begin
        for (int i = 0; i < 3; i++) m_act[i] = m_sh[i];
        m_dirty = 1'b0;
      end
      m_fcnt = (m_fcnt + 1) % FMOD;
    end
    if (we) begin
      case (a)
        3'd0: begin m_sh[0] = clampv(wd); m_dirty = 1'b1; end
        3'd1: begin m_sh[1] = wd;         m_dirty = 1'b1; end
        3'd2: begin m_sh[2] = wd;         m_dirty = 1'b1; end
        3'd3: m_irq = 1'b0;
        3'd4: m_freeze = wd[0];
        default: ;
      endcase
    end
    if (commit_now) m_irq = 1'b1;
    #1;
    check("paddle_x",   32'(paddle_x),   32'(m_act[0]));
    check("ball_x",     32'(ball_x),     32'(m_act[1]));
    check("ball_y",     32'(ball_y),     32'(m_act[2]));
    check("frame_tick", 32'(frame_tick), 32'(m_tick));
    check("frame_cnt",  32'(frame_cnt),  32'(m_fcnt));
    check("cpu_rdata",  32'(cpu_rdata),  32'(m_rdata));
`ifdef PONG_FRAME_IRQ_EN
    check("frame_irq",  32'(frame_irq),  32'(m_irq));
`endif
  endtask

  task automatic idle(input int n, input logic vs);
    repeat (n) tick(3'd0, 1'b0, 1'b0, 16'd0, vs);
  endtask

  task automatic rnd_tick(input logic vs);
    logic [2:0]  a;
    logic        we, re;
    logic [15:0] wd;
    a  = 3'($urandom_range(0, 7));
    we = ($urandom_range(0, 3) == 0);
    re = 1'($urandom_range(0, 1));
    wd = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 700)) : 16'($urandom);
    tick(a, we, re, wd, vs);
  endtask

  // One frame: vsync low for four clocks, then high for four
  task automatic frame(input bit rnd);
    for (int i = 0; i < 8; i++) begin
      if (rnd) rnd_tick(i >= 4);
      else     idle(1, i >= 4);
    end
  endtask

  task automatic do_reset();
    cpu_addr = 3'd0; cpu_we = 1'b0; cpu_re = 1'b0; cpu_wdata = 16'd0;
    vsync_in = 1'b1;
    rst_n    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  int          fc0;
  logic [15:0] by0;

  initial begin
    do_reset();
    check("rst_paddle", 32'(paddle_x),   32'd0);
    check("rst_fcnt",   32'(frame_cnt),  32'd0);
    check("rst_tick",   32'(frame_tick), 32'd0);
    check("rst_rdata",  32'(cpu_rdata),  32'd0);

    // Idle status read
    idle(2, 1'b1);
    tick(3'd3, 1'b0, 1'b1, 16'd0, 1'b1);
    check("t1_status", 32'(cpu_rdata), 32'h0000);

    // Mid-frame write only shows after vsync
    tick(3'd0, 1'b1, 1'b0, 16'd300, 1'b1);
    tick(3'd0, 1'b0, 1'b1, 16'd0, 1'b1);
    check("t2_shadow_rb", 32'(cpu_rdata), 32'd300);
    idle(3, 1'b1);
    check("t2_hold", 32'(paddle_x), 32'd0);
    idle(3, 1'b0);
    check("t2_pre_commit", 32'(paddle_x), 32'd0);
    idle(1, 1'b0);
    check("t2_commit", 32'(paddle_x), 32'd300);
    check("t2_tick", 32'(frame_tick), 32'd1);
    tick(3'd3, 1'b0, 1'b1, 16'd0, 1'b0);
    check("t2_tick_once", 32'(frame_tick), 32'd0);
    check("t2_dirty_clr", 32'(cpu_rdata), 32'h0010);
    idle(4, 1'b1);

    // Paddle clamp
    tick(3'd0, 1'b1, 1'b0, 16'd600, 1'b1);
    tick(3'd0, 1'b0, 1'b1, 16'd0, 1'b1);
    check("t3_clamp_rb", 32'(cpu_rdata), 32'd480);
    frame(1'b0);
    check("t3_clamp_act", 32'(paddle_x), 32'd480);
    tick(3'd0, 1'b1, 1'b0, 16'hFFFF, 1'b1);
    tick(3'd0, 1'b0, 1'b1, 16'd0, 1'b1);
    check("t3_ffff_rb", 32'(cpu_rdata), 32'd480);
    tick(3'd0, 1'b1, 1'b0, 16'd481, 1'b1);
    tick(3'd0, 1'b0, 1'b1, 16'd0, 1'b1);
    check("t3_481_rb", 32'(cpu_rdata), 32'd480);
    tick(3'd0, 1'b1, 1'b0, 16'd480, 1'b1);
    tick(3'd0, 1'b0, 1'b1, 16'd0, 1'b1);
    check("t3_480_rb", 32'(cpu_rdata), 32'd480);

    // Write landing exactly in the commit cycle
    tick(3'd1, 1'b1, 1'b0, 16'd20, 1'b1);
    idle(1, 1'b1);
    idle(3, 1'b0);
    tick(3'd1, 1'b1, 1'b0, 16'd50, 1'b0);
    check("t4_first", 32'(ball_x), 32'd20);
    tick(3'd3, 1'b0, 1'b1, 16'd0, 1'b0);
    check("t4_dirty", 32'(cpu_rdata[0]), 32'd1);
    tick(3'd1, 1'b0, 1'b1, 16'd0, 1'b0);
    check("t4_shadow", 32'(cpu_rdata), 32'd50);
    idle(4, 1'b1);
    frame(1'b0);
    check("t4_second", 32'(ball_x), 32'd50);

    // Freeze holds outputs while frames advance
    tick(3'd4, 1'b1, 1'b0, 16'd1, 1'b1);
    tick(3'd2, 1'b1, 1'b0, 16'd99, 1'b1);
    fc0 = m_fcnt;
    repeat (3) frame(1'b0);
    check("t5_frozen", 32'(ball_y), 32'd0);
    check("t5_fcnt", 32'(frame_cnt), 32'((fc0 + 3) % FMOD));
    tick(3'd4, 1'b0, 1'b1, 16'd0, 1'b1);
    check("t5_ctrl_rb", 32'(cpu_rdata), 32'd1);
    tick(3'd4, 1'b1, 1'b0, 16'd0, 1'b1);
    frame(1'b0);
    check("t5_unfrozen", 32'(ball_y), 32'd99);

    // Async reset while the FSM sits in COMMIT
    tick(3'd0, 1'b1, 1'b0, 16'd100, 1'b1);
    idle(1, 1'b1);
    idle(3, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_paddle", 32'(paddle_x),  32'd0);
    check("rst_mid_fcnt",   32'(frame_cnt), 32'd0);
    do_reset();
    frame(1'b0);
    check("rst_mid_after", 32'(paddle_x), 32'd0);
    tick(3'd0, 1'b0, 1'b1, 16'd0, 1'b1);
    check("rst_mid_shadow", 32'(cpu_rdata), 32'd0);

    // Random traffic across many frames
    repeat (150) frame(1'b1);

`ifdef PONG_FRAME_IRQ_EN
    do_reset();
    frame(1'b0);
    check("irq_set", 32'(frame_irq), 32'd1);
    tick(3'd3, 1'b1, 1'b0, 16'd0, 1'b1);
    check("irq_clr", 32'(frame_irq), 32'd0);
    idle(3, 1'b0);
    tick(3'd3, 1'b1, 1'b0, 16'd0, 1'b0);
    check("irq_coincide", 32'(frame_irq), 32'd1);
    idle(4, 1'b1);
`endif

    // Frame counter wrap
    do_reset();
    repeat (FMOD) frame(1'b0);
    check("t6_wrap", 32'(frame_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
